// File: rtl/boot_loader_writer.sv
// Loads a framed UART byte stream into instruction BRAM as little-endian words.
// Frame: LEN_LO, LEN_HI, 4*N data bytes, CSUM (mod-256 sum of data bytes).
module boot_loader_writer #(
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_WORDS  = 512
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_data,
  output logic [3:0]            o_mem_we,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [15:0]           o_word_count
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  localparam logic [15:0] MAXW = 16'(MAX_WORDS);

  state_t      state;
  state_t      state_n;
  logic [1:0]  lane;
  logic [15:0] len;
  logic [15:0] len_n;
  logic [7:0]  sum;
  logic [23:0] word;
  logic        acc;
  logic        arm;

  assign acc   = i_rx_valid && o_rx_ready;
  assign len_n = {i_rx_data, len[7:0]};
  assign arm   = i_start &&
                 (state == IDLE || state == DONE || state == ERR);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (i_start) state_n = LEN0;
      LEN0:  if (acc) state_n = LEN1;
      LEN1: begin
        if (acc) begin
          if (len_n > MAXW)        state_n = ERR;
          else if (len_n == 16'd0) state_n = CSUM;
          else                     state_n = DATA;
        end
      end
      DATA:  if (acc && lane == 2'd3) state_n = WRITE;
      WRITE: begin
        if (o_word_count + 16'd1 == len) state_n = CSUM;
        else                             state_n = DATA;
      end
      CSUM: begin
        if (acc) state_n = (sum == i_rx_data) ? DONE : ERR;
      end
      DONE:  if (i_start) state_n = LEN0;
      ERR:   if (i_start) state_n = LEN0;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      lane         <= '0;
      len          <= '0;
      sum          <= '0;
      word         <= '0;
      o_rx_ready   <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_mem_we     <= '0;
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
      o_word_count <= '0;
    end else begin
      state      <= state_n;
      o_rx_ready <= state_n inside {LEN0, LEN1, DATA, CSUM};
      o_busy     <= state_n inside {LEN0, LEN1, DATA, WRITE, CSUM};
      o_done     <= state_n == DONE;
      o_error    <= state_n == ERR;
      o_mem_we   <= 4'h0;
      if (arm) begin
        lane         <= '0;
        len          <= '0;
        sum          <= '0;
        o_word_count <= '0;
      end
      if (acc) begin
        unique case (state)
          LEN0: len[7:0]  <= i_rx_data;
          LEN1: len[15:8] <= i_rx_data;
          DATA: begin
            sum  <= sum + i_rx_data;
            lane <= lane + 2'd1;
            unique case (lane)
              2'd0: word[7:0]   <= i_rx_data;
              2'd1: word[15:8]  <= i_rx_data;
              2'd2: word[23:16] <= i_rx_data;
              2'd3: begin
                o_mem_we   <= 4'hF;
                o_mem_addr <= ADDR_WIDTH'(o_word_count);
                o_mem_data <= {i_rx_data, word};
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      if (state == WRITE) o_word_count <= o_word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_boot_loader_writer.sv
// Directed bench: expected BRAM writes go into a queue, a monitor pops them.
// Status flags are checked directly after each frame.
module tb_boot_loader_writer;

  localparam int AW = 9;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic          o_rx_ready;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_data;
  logic [3:0]    o_mem_we;
  logic          o_busy;
  logic          o_done;
  logic          o_error;
  logic [15:0]   o_word_count;

  int pass_cnt = 0;
  int total    = 0;
  int gap_cnt  = 0;
  logic [40:0] exp_q[$];

  boot_loader_writer #(.ADDR_WIDTH(AW), .MAX_WORDS(512)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .o_mem_we     (o_mem_we),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_word_count (o_word_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Write monitor: every strobe must match the head of the queue.
  always @(negedge i_clk) begin
    if (o_busy && !o_rx_ready) gap_cnt++;
    if (o_mem_we != 4'h0) begin
      chk("we_value", 64'(o_mem_we), 64'hF);
      chk("ready_low_in_write", 64'(o_rx_ready), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'({o_mem_addr, o_mem_data}), 64'd0);
        total++;
        $display("FAIL unexpected_write: strobe with empty queue");
      end else begin
        chk("write_addr_data", 64'({o_mem_addr, o_mem_data}),
            64'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_w(input int a, input logic [31:0] d);
    exp_q.push_back({AW'(a), d});
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (o_rx_ready) begin
        @(posedge i_clk);
        @(negedge i_clk);
        return;
      end
      @(negedge i_clk);
    end
    total++;
    $display("FAIL send_timeout: byte %0h never accepted", b);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic chk_status(input string name, input logic done,
                            input logic err, input logic [15:0] cnt);
    chk({name, "_done"}, 64'(o_done), 64'(done));
    chk({name, "_error"}, 64'(o_error), 64'(err));
    chk({name, "_count"}, 64'(o_word_count), 64'(cnt));
    chk({name, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    logic [7:0] f1[$];
    f1 = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h00, 8'h00,
           8'hB7, 8'h00, 8'h01, 8'h00};
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("reset_outputs", 64'({o_rx_ready, o_busy, o_done, o_error,
        o_mem_we, o_mem_addr, o_mem_data, o_word_count}), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Reset in the middle of a word
    pulse_start();
    send_seq('{8'h01, 8'h00, 8'h13, 8'h01});
    #2 i_rst_n = 1'b0;
    #1 chk("midreset_outputs", 64'({o_rx_ready, o_busy, o_done, o_error,
        o_mem_we, o_mem_addr, o_mem_data, o_word_count}), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (8) @(negedge i_clk);
    chk("midreset_idle", 64'({o_busy, o_rx_ready}), 64'd0);
    i_rx_valid = 1'b0;

    // Good two-word frame
    push_w(0, 32'h0000_0113);
    push_w(1, 32'h0001_00B7);
    pulse_start();
    send_seq(f1);
    send_byte(8'hCC);
    i_rx_valid = 1'b0;
    chk_status("good", 1'b1, 1'b0, 16'd2);

    // Re-arm from DONE, same frame with bad checksum
    pulse_start();
    chk("rearm_busy_ready", 64'({o_busy, o_rx_ready, o_done}), 64'b110);
    push_w(0, 32'h0000_0113);
    push_w(1, 32'h0001_00B7);
    send_seq(f1);
    send_byte(8'hCD);
    i_rx_valid = 1'b0;
    chk_status("badsum", 1'b0, 1'b1, 16'd2);

    // Length 513 rejected after LEN_HI
    pulse_start();
    send_seq('{8'h01, 8'h02});
    i_rx_valid = 1'b0;
    chk("toolong_ready", 64'(o_rx_ready), 64'd0);
    chk_status("toolong", 1'b0, 1'b1, 16'd0);

    // Empty image, good and bad checksum
    pulse_start();
    send_seq('{8'h00, 8'h00, 8'h00});
    i_rx_valid = 1'b0;
    chk_status("empty_ok", 1'b1, 1'b0, 16'd0);
    pulse_start();
    send_seq('{8'h00, 8'h00, 8'h01});
    i_rx_valid = 1'b0;
    chk_status("empty_bad", 1'b0, 1'b1, 16'd0);

    // Three words, valid held high throughout; ready gaps only in WRITE
    push_w(0, 32'hDEAD_BEEF);
    push_w(1, 32'h0000_0000);
    push_w(2, 32'hFFFF_FFFF);
    gap_cnt = 0;
    pulse_start();
    send_seq('{8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
               8'h00, 8'h00, 8'h00, 8'h00,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h34});
    i_rx_valid = 1'b0;
    chk("write_gap_cycles", 64'(gap_cnt), 64'd3);
    chk_status("three", 1'b1, 1'b0, 16'd3);

    repeat (4) @(negedge i_clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
